// File: rtl/vend_pkg.sv
// Shared types and queue helpers for the beverage dispenser actuator controller.
package vend_pkg;

  localparam int QCNT_W = 2;
  localparam logic [QCNT_W-1:0] QMAX = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOTOR     = 2'd1,
    WAIT_DROP = 2'd2,
    FAULT     = 2'd3
  } vend_state_e;

  // Next value of a saturating request counter; simultaneous inc and dec cancel.
  function automatic logic [QCNT_W-1:0] q_next(input logic [QCNT_W-1:0] cnt,
                                               input logic              inc,
                                               input logic              dec);
    logic [QCNT_W-1:0] nxt;
    nxt = cnt;
    if (inc && !dec) begin
      if (cnt != QMAX) nxt = cnt + QCNT_W'(1);
      else             nxt = cnt;
    end else if (dec && !inc) begin
      nxt = cnt - QCNT_W'(1);
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

  // A request is lost when the counter is full and nothing leaves in the same cycle.
  function automatic logic q_ovf(input logic [QCNT_W-1:0] cnt,
                                 input logic              inc,
                                 input logic              dec);
    return inc & ~dec & (cnt == QMAX);
  endfunction

endpackage

// File: rtl/coin_eject_ctrl.sv
// Change-coin ejector: saturating coin queue plus a fixed-width solenoid pulse.
// Pulses are separated by at least one low cycle; runs independently of vending.
module coin_eject_ctrl
  import vend_pkg::*;
#(
  parameter int CHANGE_CYCLES = 20
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic req_i,
  input  logic clr_i,
  output logic coin_eject_o,
  output logic busy_nxt_o,
  output logic ovf_o
);

  localparam int CNT_W = (CHANGE_CYCLES > 1) ? $clog2(CHANGE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHANGE_CYCLES - 1);

  logic [QCNT_W-1:0] chg_pend_q, chg_pend_d;
  logic              eject_q, eject_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_s;

  // Next-state for the coin queue and pulse timer; a new coin starts only while the solenoid is low.
  always_comb begin
    chg_pend_d = chg_pend_q;
    eject_d    = eject_q;
    cnt_d      = cnt_q;
    start_s    = ~eject_q & (chg_pend_q != '0);
    ovf_o      = 1'b0;
    if (clr_i) begin
      chg_pend_d = '0;
      eject_d    = 1'b0;
      cnt_d      = '0;
    end else begin
      if (eject_q) begin
        if (cnt_q == CNT_LAST) begin
          eject_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (start_s) begin
        eject_d = 1'b1;
        cnt_d   = '0;
      end else begin
        eject_d = 1'b0;
      end
      chg_pend_d = q_next(chg_pend_q, req_i, start_s);
      ovf_o      = q_ovf(chg_pend_q, req_i, start_s);
    end
    busy_nxt_o = (chg_pend_d != '0) | eject_d;
  end

  // Coin queue and solenoid registers; reset drops the solenoid immediately.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      chg_pend_q <= '0;
      eject_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      chg_pend_q <= chg_pend_d;
      eject_q    <= eject_d;
      cnt_q      <= cnt_d;
    end
  end

  assign coin_eject_o = eject_q;

endmodule

// File: rtl/beverage_dispenser.sv
// Actuator controller downstream of the vending FSM: queues vend and change
// requests, runs the release motor, confirms each can against the drop sensor
// with a timeout, and halts vending on a missed drop until an operator clears it.
module beverage_dispenser
  import vend_pkg::*;
#(
  parameter int MOTOR_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 500,
  parameter int CHANGE_CYCLES  = 20
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              po_beverage,
  input  logic              po_money,
  input  logic              drop_sensor,
  input  logic              fault_clr,
  output logic              motor_en,
  output logic              coin_eject,
  output logic [QCNT_W-1:0] pend_cnt,
  output logic              busy,
  output logic              fault,
  output logic              overflow
);

  localparam int TMR_MAX = (MOTOR_CYCLES > TIMEOUT_CYCLES) ? MOTOR_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] MOTOR_LAST   = TMR_W'(MOTOR_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  vend_state_e       state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [QCNT_W-1:0] pend_q, pend_d;
  logic              motor_q, fault_q, ovf_q, ovf_d, busy_q, busy_d;
  logic              drop_meta_q, drop_sync_q, drop_prev_q;
  logic              drop_evt_s, done_s, vend_ovf_s;
  logic              chg_busy_nxt_s, chg_ovf_s;

  // Two-flop synchronizer for the raw drop sensor plus a delay flop for edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      drop_meta_q <= 1'b0;
      drop_sync_q <= 1'b0;
      drop_prev_q <= 1'b0;
    end else begin
      drop_meta_q <= drop_sensor;
      drop_sync_q <= drop_meta_q;
      drop_prev_q <= drop_sync_q;
    end
  end

  assign drop_evt_s = drop_sync_q & ~drop_prev_q;

  // Vend FSM next-state, shared motor/timeout timer, vend queue and sticky overflow.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    done_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          state_d = MOTOR;
          tmr_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      MOTOR: begin
        if (tmr_q == MOTOR_LAST) begin
          state_d = WAIT_DROP;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      WAIT_DROP: begin
        // A drop in the expiry cycle still confirms the vend.
        if (drop_evt_s) begin
          done_s  = 1'b1;
          state_d = IDLE;
          tmr_d   = '0;
        end else if (tmr_q == TIMEOUT_LAST) begin
          state_d = FAULT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      FAULT: begin
        // The failed vend stays counted in pend_q and is retried from IDLE.
        if (fault_clr) state_d = IDLE;
        else           state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
    pend_d     = q_next(pend_q, po_beverage, done_s);
    vend_ovf_s = q_ovf(pend_q, po_beverage, done_s);
    ovf_d      = (ovf_q & ~fault_clr) | vend_ovf_s | chg_ovf_s;
    busy_d     = (state_d != IDLE) | (pend_d != '0) | chg_busy_nxt_s;
  end

  // State and output registers; reset stops the motor without waiting for a clock.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      pend_q  <= '0;
      motor_q <= 1'b0;
      fault_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pend_q  <= pend_d;
      motor_q <= (state_d == MOTOR);
      fault_q <= (state_d == FAULT);
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  // No synchronous flush source exists at this level, so the ejector clear is held off.
  coin_eject_ctrl #(
    .CHANGE_CYCLES (CHANGE_CYCLES)
  ) u_coin_eject_ctrl (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .req_i        (po_money),
    .clr_i        (1'b0),
    .coin_eject_o (coin_eject),
    .busy_nxt_o   (chg_busy_nxt_s),
    .ovf_o        (chg_ovf_s)
  );

  assign motor_en = motor_q;
  assign pend_cnt = pend_q;
  assign busy     = busy_q;
  assign fault    = fault_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_beverage_dispenser.sv
// Scoreboard bench for beverage_dispenser: stimulus pushes expected motor and
// coin pulses (rise cycle, length); a monitor pops and compares on each pulse end.
module tb_beverage_dispenser;

  typedef struct {
    int rise;
    int len;
  } pulse_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       po_beverage = 1'b0;
  logic       po_money = 1'b0;
  logic       drop_sensor = 1'b0;
  logic       fault_clr = 1'b0;
  logic       motor_en, coin_eject, busy, fault, overflow;
  logic [1:0] pend_cnt;

  int     cyc = 0;
  int     checks = 0;
  int     failures = 0;
  pulse_t exp_motor[$];
  pulse_t exp_coin[$];

  beverage_dispenser #(
    .MOTOR_CYCLES   (4),
    .TIMEOUT_CYCLES (16),
    .CHANGE_CYCLES  (3)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .po_beverage (po_beverage),
    .po_money    (po_money),
    .drop_sensor (drop_sensor),
    .fault_clr   (fault_clr),
    .motor_en    (motor_en),
    .coin_eject  (coin_eject),
    .pend_cnt    (pend_cnt),
    .busy        (busy),
    .fault       (fault),
    .overflow    (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  // Edge counter: at a negedge, cyc equals the index of the last rising edge.
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: times each motor and coin pulse and compares it with the scoreboard.
  logic m_prev = 1'b0;
  logic c_prev = 1'b0;
  int   m_rise = 0;
  int   c_rise = 0;
  always @(negedge sys_clk) begin
    pulse_t e;
    if (motor_en && !m_prev) m_rise = cyc;
    if (!motor_en && m_prev) begin
      if (exp_motor.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL motor_unexpected: pulse rise=%0d len=%0d expected none", m_rise, cyc - m_rise);
      end else begin
        e = exp_motor.pop_front();
        chk("motor_rise", m_rise, e.rise);
        if (e.len >= 0) chk("motor_len", cyc - m_rise, e.len);
      end
    end
    m_prev = motor_en;
    if (coin_eject && !c_prev) c_rise = cyc;
    if (!coin_eject && c_prev) begin
      if (exp_coin.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL coin_unexpected: pulse rise=%0d len=%0d expected none", c_rise, cyc - c_rise);
      end else begin
        e = exp_coin.pop_front();
        chk("coin_rise", c_rise, e.rise);
        chk("coin_len", cyc - c_rise, e.len);
      end
    end
    c_prev = coin_eject;
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge sys_clk);
  endtask

  // One-cycle vend request from a negedge; n is the edge that samples it.
  task automatic pulse_bev(input logic money, output int n);
    n = cyc + 1;
    po_beverage = 1'b1;
    po_money = money;
    @(negedge sys_clk);
    po_beverage = 1'b0;
    po_money = 1'b0;
  endtask

  // Raw sensor high for two cycles starting at the negedge after edge c.
  task automatic drop_at(input int c);
    wait_to(c);
    drop_sensor = 1'b1;
    wait_to(c + 2);
    drop_sensor = 1'b0;
  endtask

  task automatic clr_pulse();
    fault_clr = 1'b1;
    @(negedge sys_clk);
    fault_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached expected earlier finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge sys_clk);
    chk("rst_motor", motor_en, 0);
    chk("rst_coin", coin_eject, 0);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_ovf", overflow, 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Single vend, drop two cycles after the motor stops.
    pulse_bev(1'b0, n);
    exp_motor.push_back('{n + 1, 4});
    chk("s1_pend_accept", pend_cnt, 1);
    chk("s1_busy_accept", busy, 1);
    drop_at(n + 6);
    wait_to(n + 10);
    chk("s1_pend_done", pend_cnt, 0);
    chk("s1_fault", fault, 0);
    chk("s1_busy_done", busy, 0);

    // Vend with change in the same cycle: both actuators start together.
    pulse_bev(1'b1, n);
    exp_motor.push_back('{n + 1, 4});
    exp_coin.push_back('{n + 1, 3});
    wait_to(n + 2);
    chk("s2_coin_with_motor", coin_eject, 1);
    chk("s2_motor_with_coin", motor_en, 1);
    drop_at(n + 6);
    wait_to(n + 10);
    chk("s2_pend_done", pend_cnt, 0);
    chk("s2_busy_done", busy, 0);

    // Four back-to-back requests saturate the queue; three runs follow.
    n = cyc + 1;
    po_beverage = 1'b1;
    repeat (4) @(negedge sys_clk);
    po_beverage = 1'b0;
    chk("s3_pend_sat", pend_cnt, 3);
    chk("s3_ovf_set", overflow, 1);
    for (int k = 0; k < 3; k++) exp_motor.push_back('{n + 1 + 8 * k, 4});
    for (int k = 0; k < 3; k++) drop_at(n + 5 + 8 * k);
    wait_to(n + 26);
    chk("s3_pend_done", pend_cnt, 0);
    chk("s3_ovf_sticky", overflow, 1);
    clr_pulse();
    chk("s3_ovf_clr", overflow, 0);
    chk("s3_fault_after_clr", fault, 0);

    // Timeout: no drop faults 16 cycles after the motor stops, then retry.
    pulse_bev(1'b0, n);
    exp_motor.push_back('{n + 1, 4});
    wait_to(n + 20);
    chk("s4_fault_early", fault, 0);
    wait_to(n + 21);
    chk("s4_fault_set", fault, 1);
    chk("s4_motor_off", motor_en, 0);
    chk("s4_pend_kept", pend_cnt, 1);
    chk("s4_busy_fault", busy, 1);
    wait_to(n + 22);
    clr_pulse();
    chk("s4_fault_clr", fault, 0);
    exp_motor.push_back('{n + 24, 4});
    drop_at(n + 28);
    wait_to(n + 32);
    chk("s4_pend_done", pend_cnt, 0);
    chk("s4_fault_done", fault, 0);

    // Change requests while faulted still eject, with a one-cycle gap.
    pulse_bev(1'b0, n);
    exp_motor.push_back('{n + 1, 4});
    wait_to(n + 21);
    chk("s5_fault_set", fault, 1);
    po_money = 1'b1;
    repeat (2) @(negedge sys_clk);
    po_money = 1'b0;
    exp_coin.push_back('{n + 23, 3});
    exp_coin.push_back('{n + 27, 3});
    wait_to(n + 32);
    chk("s5_fault_held", fault, 1);
    chk("s5_coin_idle", coin_eject, 0);
    exp_motor.push_back('{n + 34, 4});
    clr_pulse();
    drop_at(n + 38);
    wait_to(n + 42);
    chk("s5_pend_done", pend_cnt, 0);
    chk("s5_busy_done", busy, 0);

    // Reset during a motor run clears outputs without a clock edge.
    pulse_bev(1'b0, n);
    exp_motor.push_back('{n + 1, -1});
    wait_to(n + 2);
    chk("s6_motor_running", motor_en, 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("s6_motor_async", motor_en, 0);
    chk("s6_pend_async", pend_cnt, 0);
    chk("s6_busy_async", busy, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (12) @(negedge sys_clk);
    chk("s6_motor_quiet", motor_en, 0);
    chk("s6_pend_quiet", pend_cnt, 0);
    chk("s6_busy_quiet", busy, 0);

    chk("sb_motor_left", exp_motor.size(), 0);
    chk("sb_coin_left", exp_coin.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
